// File: rtl/ex_mem_pipe_if.sv
// Data-memory bus between the EX/MEM pipeline register and the data cache.
// The pipeline register drives requests (master); the cache answers with dhit/dmemload (slave).
interface ex_mem_pipe_if #(
   parameter int unsigned WORD_W = 32
);
   logic              dmemREN;
   logic              dmemWEN;
   logic [WORD_W-1:0] dmemaddr;
   logic [WORD_W-1:0] dmemstore;
   logic              dhit;
   logic [WORD_W-1:0] dmemload;

   modport master (
      output dmemREN,
      output dmemWEN,
      output dmemaddr,
      output dmemstore,
      input  dhit,
      input  dmemload
   );

   modport slave (
      input  dmemREN,
      input  dmemWEN,
      input  dmemaddr,
      input  dmemstore,
      output dhit,
      output dmemload
   );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with a one-shot data-memory handshake FSM for the 5-stage MIPS core.
// Optional feature: define EXMEM_STALLCNT_EN to add the 32-bit stallcnt output.
module ex_mem_pipe #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              W,
   input  logic              flush,
   input  logic              exDRE,
   input  logic              exDWE,
   input  logic              exHALT,
   input  logic              exMemToReg,
   input  logic              exWEN,
   input  logic              exJALflag,
   input  logic [REG_W-1:0]  exwsel,
   input  logic [WORD_W-1:0] exALUout,
   input  logic [WORD_W-1:0] exrdat2,
   input  logic [WORD_W-1:0] exiaddr,
   ex_mem_pipe_if.master     dmem,
   output logic              memstall,
   output logic              memHALT,
   output logic              memMemToReg,
   output logic              memWEN,
   output logic              memJALflag,
   output logic [REG_W-1:0]  memwsel,
   output logic [WORD_W-1:0] memALUout,
   output logic [WORD_W-1:0] memrdat2,
   output logic [WORD_W-1:0] memiaddr,
   output logic [WORD_W-1:0] memdload
`ifdef EXMEM_STALLCNT_EN
   ,
   output logic [31:0]       stallcnt
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_dmemREN;
   logic              r_dmemWEN;
   logic              r_memstall;
   logic              r_memHALT;
   logic              r_memMemToReg;
   logic              r_memWEN;
   logic              r_memJALflag;
   logic [REG_W-1:0]  r_memwsel;
   logic [WORD_W-1:0] r_memALUout;
   logic [WORD_W-1:0] r_memrdat2;
   logic [WORD_W-1:0] r_memiaddr;
   logic [WORD_W-1:0] r_memdload;

   logic w_load;
   logic w_ctl_en;
   logic w_req_en;
   logic w_dre;
   logic w_dwe;
   logic w_wen;
   logic w_req;

   // flush squashes control; a latched halt additionally kills writes and memory requests.
   always_comb begin
      w_load   = W & ~r_memstall;
      w_ctl_en = ~flush;
      w_req_en = ~flush & ~r_memHALT;
      w_dwe    = w_req_en & exDWE;
      w_dre    = w_req_en & exDRE & ~exDWE;
      w_wen    = w_req_en & exWEN;
      w_req    = w_dre | w_dwe;
   end

   // Handshake FSM: requests and memstall are registered so they drop asynchronously on reset.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state    <= IDLE;
         r_dmemREN  <= 1'b0;
         r_dmemWEN  <= 1'b0;
         r_memstall <= 1'b0;
         r_memdload <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_load) begin
                  if (w_req) begin
                     r_state    <= ACCESS;
                     r_dmemREN  <= w_dre;
                     r_dmemWEN  <= w_dwe;
                     r_memstall <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            ACCESS: begin
               if (dmem.dhit) begin
                  r_state    <= DONE;
                  r_dmemREN  <= 1'b0;
                  r_dmemWEN  <= 1'b0;
                  r_memstall <= 1'b0;
                  if (r_dmemREN) begin
                     r_memdload <= dmem.dmemload;
                  end
               end
            end
            default: begin
               r_state    <= IDLE;
               r_dmemREN  <= 1'b0;
               r_dmemWEN  <= 1'b0;
               r_memstall <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_memHALT     <= 1'b0;
         r_memMemToReg <= 1'b0;
         r_memWEN      <= 1'b0;
         r_memJALflag  <= 1'b0;
         r_memwsel     <= '0;
         r_memALUout   <= '0;
         r_memrdat2    <= '0;
         r_memiaddr    <= '0;
      end else if (w_load) begin
         r_memHALT     <= r_memHALT | (w_ctl_en & exHALT);
         r_memMemToReg <= w_ctl_en & exMemToReg;
         r_memWEN      <= w_wen;
         r_memJALflag  <= w_ctl_en & exJALflag;
         r_memwsel     <= exwsel;
         r_memALUout   <= exALUout;
         r_memrdat2    <= exrdat2;
         r_memiaddr    <= exiaddr;
      end
   end

`ifdef EXMEM_STALLCNT_EN
   logic [31:0] r_stallcnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stallcnt <= '0;
      end else if (r_memstall && !r_memHALT) begin
         r_stallcnt <= r_stallcnt + 32'd1;
      end
   end

   assign stallcnt = r_stallcnt;
`endif

   assign dmem.dmemREN   = r_dmemREN;
   assign dmem.dmemWEN   = r_dmemWEN;
   assign dmem.dmemaddr  = r_memALUout;
   assign dmem.dmemstore = r_memrdat2;

   assign memstall    = r_memstall;
   assign memHALT     = r_memHALT;
   assign memMemToReg = r_memMemToReg;
   assign memWEN      = r_memWEN;
   assign memJALflag  = r_memJALflag;
   assign memwsel     = r_memwsel;
   assign memALUout   = r_memALUout;
   assign memrdat2    = r_memrdat2;
   assign memiaddr    = r_memiaddr;
   assign memdload    = r_memdload;

   a_one_request : assert property (@(posedge CLK) disable iff (!nRST)
      !(r_dmemREN && r_dmemWEN));

   a_halt_sticky : assert property (@(posedge CLK) disable iff (!nRST)
      r_memHALT |=> r_memHALT);

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- EX/MEM pipeline register for the 5-stage MIPS datapath; sits directly downstream of the ID/EX register and the ALU.
- Latches EX-stage results and control and drives the data-memory request to the cache.
- Runs a small handshake FSM so each load/store issues exactly once and holds the pipe until dhit.
- Supplies the MEM/WB stage with latched result, load data and writeback control.

Parameters:
- WORD_W, 32, datapath word width (word_t).
- REG_W, 5, register-select width.

Ports:
- CLK  in  1  clock; all state on rising edge
- nRST  in  1  asynchronous active-low reset
- W  in  1  advance enable from hazard/ihit logic
- flush  in  1  insert bubble (branch/jump resolved in EX)
- exDRE  in  1  EX load request
- exDWE  in  1  EX store request
- exHALT  in  1  EX halt
- exMemToReg  in  1  writeback select
- exWEN  in  1  regfile write enable
- exJALflag  in  1  JAL writeback of link address
- exwsel  in  REG_W  destination register
- exALUout  in  WORD_W  ALU result / memory address
- exrdat2  in  WORD_W  store data
- exiaddr  in  WORD_W  PC+4 of instruction
- dhit  in  1  cache data-access complete
- dmemload  in  WORD_W  cache load data
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- dmemaddr  out  WORD_W  = memALUout
- dmemstore  out  WORD_W  = memrdat2
- memstall  out  1  MEM busy; upstream must hold
- memHALT  out  1  sticky halt
- memMemToReg, memWEN, memJALflag  out  1 each  latched control
- memwsel  out  REG_W  latched destination
- memALUout, memrdat2, memiaddr, memdload  out  WORD_W  latched data; memdload = captured load word

Behaviour:
- Reset (nRST low, asynchronous): all outputs and state 0; FSM = IDLE.
- Load: when W=1 and memstall=0, all mem* registers take ex* values next edge. When flush=1 in the same cycle, control bits (DRE, DWE, WEN, HALT, MemToReg, JALflag) load 0 instead; data fields load normally. flush has priority over ex* control.
- Hold: W=0 or memstall=1 -> all latched fields unchanged.
- FSM states: IDLE, ACCESS, DONE.
- IDLE -> ACCESS on a load edge with ex DRE|DWE=1 (post-flush).
- ACCESS: dmemREN=memDRE, dmemWEN=memDWE, memstall=1. On dhit=1: memdload <= dmemload (loads only; stores leave memdload unchanged), go to DONE.
- DONE: requests 0, memstall=0; the next load edge re-evaluates as from IDLE (go to ACCESS if new request, else IDLE). With no load edge, remain DONE and requests stay 0 (no re-issue).
- dmemREN/dmemWEN are never both 1; if both ex DRE and DWE are set, DWE wins.
- dhit arriving in IDLE or DONE: ignored.
- Latency: non-memory instruction visible on mem* 1 cycle after load edge; memory instruction stalls for (dhit cycle - entry cycle + 1) cycles, minimum 1.
- memHALT: set on load of exHALT=1; stays 1 until nRST; once set, further load edges do not change memWEN or the dmem requests (all forced 0).
- Reset mid-ACCESS: requests drop immediately (async); state IDLE.

Optional Feature:
- Macro: EXMEM_STALLCNT_EN
- Defined: adds output stallcnt (32 bits), reset 0, +1 every cycle memstall=1, wraps 0xFFFFFFFF->0, frozen once memHALT=1.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: nRST low mid-run -> all outputs 0, dmemREN=0 same cycle without a clock edge.
- ALU op: exALUout=0x0000_00A5, exWEN=1, exwsel=8, W=1 -> next cycle memALUout=0xA5, memWEN=1, memwsel=8, memstall=0.
- Load with 3-cycle miss: exDRE=1, exALUout=0x100; dhit on 3rd ACCESS cycle with dmemload=0xDEADBEEF -> dmemREN=1 and memstall=1 for 3 cycles, then memdload=0xDEADBEEF, dmemREN=0, no second request.
- Store hit: exDWE=1, exrdat2=0x1234, dhit same cycle -> dmemWEN=1 for 1 cycle, dmemstore=0x1234, memstall=1 for 1 cycle.
- Flush: flush=1 with exDWE=1, exWEN=1 -> next cycle dmemWEN=0, memWEN=0, FSM IDLE.
- Halt: exHALT=1 loaded -> memHALT=1 persists; a subsequent exWEN=1 load leaves memWEN=0; with EXMEM_STALLCNT_EN, stallcnt equals total prior stall cycles and freezes.
